// File: rtl/car_alarm_ctrl.sv
// Car alarm controller: registered lights-left-on reminder plus an arm/disarm FSM
// with exit delay, entry delay, timed siren and retrigger lockout. All outputs registered.
module car_alarm_ctrl #(
  parameter int NUM_DOORS    = 4,
  parameter int ARM_DELAY    = 4,
  parameter int ENTRY_DELAY  = 8,
  parameter int SIREN_CYCLES = 16,
  parameter int MAX_TRIGGERS = 3,
  parameter int CNT_W        = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 IgnitionSignalOn,
  input  logic                 CarLightsOnSign,
  input  logic [NUM_DOORS-1:0] OpenDoorSign,
  input  logic                 ArmRequest,
  input  logic                 DisarmRequest,
  output logic                 PassiveSignal,
  output logic                 SirenOn,
  output logic                 Armed,
  output logic                 ArmFail,
  output logic [2:0]           AlarmState,
  output logic [NUM_DOORS-1:0] TriggerDoor
);

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_ARMING   = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4,
    S_LOCKOUT  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] ARM_LOAD   = CNT_W'(ARM_DELAY - 1);
  localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DELAY - 1);
  localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_CYCLES - 1);
  localparam logic [3:0]       TRIG_MAX   = 4'(MAX_TRIGGERS);

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [3:0]           r_trig;
  logic                 r_passive;
  logic                 r_siren;
  logic                 r_armed;
  logic                 r_fail;
  logic [NUM_DOORS-1:0] r_trig_door;

  logic                 w_door_open;
  logic [3:0]           w_trig_next;

  assign w_door_open = |OpenDoorSign;
  assign w_trig_next = (r_trig == TRIG_MAX) ? r_trig : r_trig + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_DISARMED;
      r_cnt       <= '0;
      r_trig      <= '0;
      r_passive   <= 1'b0;
      r_siren     <= 1'b0;
      r_armed     <= 1'b0;
      r_fail      <= 1'b0;
      r_trig_door <= '0;
    end else begin
      r_passive <= CarLightsOnSign & w_door_open & ~IgnitionSignalOn;
      r_fail    <= 1'b0;
      if (DisarmRequest) begin
        r_state     <= S_DISARMED;
        r_cnt       <= '0;
        r_trig      <= '0;
        r_siren     <= 1'b0;
        r_armed     <= 1'b0;
        r_trig_door <= '0;
      end else begin
        case (r_state)
          S_DISARMED: begin
            if (ArmRequest && !IgnitionSignalOn) begin
              r_state <= S_ARMING;
              r_cnt   <= ARM_LOAD;
            end
          end
          S_ARMING: begin
            // Doors are only judged on the last exit-delay cycle.
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - 1'b1;
            end else if (w_door_open) begin
              r_state <= S_DISARMED;
              r_fail  <= 1'b1;
            end else begin
              r_state <= S_ARMED;
              r_armed <= 1'b1;
            end
          end
          S_ARMED: begin
            if (IgnitionSignalOn) begin
              r_state <= S_ALARM;
              r_cnt   <= SIREN_LOAD;
              r_siren <= 1'b1;
              r_trig  <= w_trig_next;
            end else if (w_door_open) begin
              r_state     <= S_ENTRY;
              r_cnt       <= ENTRY_LOAD;
              r_trig_door <= r_trig_door | OpenDoorSign;
            end
          end
          S_ENTRY: begin
            r_trig_door <= r_trig_door | OpenDoorSign;
            if (IgnitionSignalOn || r_cnt == '0) begin
              r_state <= S_ALARM;
              r_cnt   <= SIREN_LOAD;
              r_siren <= 1'b1;
              r_trig  <= w_trig_next;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          S_ALARM: begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - 1'b1;
            end else begin
              r_siren <= 1'b0;
              r_state <= (r_trig == TRIG_MAX) ? S_LOCKOUT : S_ARMED;
            end
          end
          S_LOCKOUT: begin
            r_siren <= 1'b0;
          end
          default: begin
            r_state <= S_DISARMED;
            r_cnt   <= '0;
            r_siren <= 1'b0;
            r_armed <= 1'b0;
          end
        endcase
      end
    end
  end

  assign PassiveSignal = r_passive;
  assign SirenOn       = r_siren;
  assign Armed         = r_armed;
  assign ArmFail       = r_fail;
  assign AlarmState    = r_state;
  assign TriggerDoor   = r_trig_door;

endmodule

// File: tb/tb_car_alarm_ctrl.sv
// Directed bench for car_alarm_ctrl: vector table for single-cycle behaviour,
// hand-written sequences for the delay, siren, lockout and reset corner cases.
module tb_car_alarm_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       IgnitionSignalOn;
  logic       CarLightsOnSign;
  logic [3:0] OpenDoorSign;
  logic       ArmRequest;
  logic       DisarmRequest;
  logic       PassiveSignal;
  logic       SirenOn;
  logic       Armed;
  logic       ArmFail;
  logic [2:0] AlarmState;
  logic [3:0] TriggerDoor;

  int n_cmp = 0;
  int n_err = 0;

  car_alarm_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .IgnitionSignalOn (IgnitionSignalOn),
    .CarLightsOnSign  (CarLightsOnSign),
    .OpenDoorSign     (OpenDoorSign),
    .ArmRequest       (ArmRequest),
    .DisarmRequest    (DisarmRequest),
    .PassiveSignal    (PassiveSignal),
    .SirenOn          (SirenOn),
    .Armed            (Armed),
    .ArmFail          (ArmFail),
    .AlarmState       (AlarmState),
    .TriggerDoor      (TriggerDoor)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, ign, lights;
    logic [3:0] door;
    logic       arm, dis;
    logic       e_pas, e_sir, e_arm, e_fail;
    logic [2:0] e_st;
    logic [3:0] e_td;
  } vec_t;

  vec_t tbl[7];

  task automatic drive(input logic r, input logic ig, input logic li,
                       input logic [3:0] dr, input logic ar, input logic ds);
    reset            = r;
    IgnitionSignalOn = ig;
    CarLightsOnSign  = li;
    OpenDoorSign     = dr;
    ArmRequest       = ar;
    DisarmRequest    = ds;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input string fld, input logic [7:0] act,
                     input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic pas, input logic sir,
                         input logic arm, input logic fail, input logic [2:0] st,
                         input logic [3:0] td);
    chk(nm, "PassiveSignal", {7'd0, PassiveSignal}, {7'd0, pas});
    chk(nm, "SirenOn",       {7'd0, SirenOn},       {7'd0, sir});
    chk(nm, "Armed",         {7'd0, Armed},         {7'd0, arm});
    chk(nm, "ArmFail",       {7'd0, ArmFail},       {7'd0, fail});
    chk(nm, "AlarmState",    {5'd0, AlarmState},    {5'd0, st});
    chk(nm, "TriggerDoor",   {4'd0, TriggerDoor},   {4'd0, td});
  endtask

  // Exit delay with all doors closed: four ARMING observations, then ARMED.
  task automatic arm_ok(input string nm);
    drive(0, 0, 0, 4'h0, 1, 0);
    tick();
    drive(0, 0, 0, 4'h0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    chk_all({nm, ".arming"}, 0, 0, 0, 0, 3'd1, 4'h0);
    tick();
    chk_all({nm, ".armed"}, 0, 0, 1, 0, 3'd2, 4'h0);
  endtask

  initial begin
    //        rst ign lit door  arm dis pas sir arm fail st    td
    tbl[0] = '{1, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 3'd0, 4'h0};
    tbl[1] = '{0, 0, 1, 4'h1, 0, 0, 1, 0, 0, 0, 3'd0, 4'h0};
    tbl[2] = '{0, 1, 1, 4'h1, 0, 0, 0, 0, 0, 0, 3'd0, 4'h0};
    tbl[3] = '{0, 1, 0, 4'h0, 1, 0, 0, 0, 0, 0, 3'd0, 4'h0};
    tbl[4] = '{0, 0, 0, 4'h0, 1, 1, 0, 0, 0, 0, 3'd0, 4'h0};
    tbl[5] = '{0, 0, 1, 4'h8, 0, 0, 1, 0, 0, 0, 3'd0, 4'h0};
    tbl[6] = '{0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 3'd0, 4'h0};

    drive(1, 0, 0, 4'h0, 0, 0);
    tick();
    tick();

    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].rst, tbl[i].ign, tbl[i].lights, tbl[i].door, tbl[i].arm, tbl[i].dis);
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].e_pas, tbl[i].e_sir, tbl[i].e_arm,
              tbl[i].e_fail, tbl[i].e_st, tbl[i].e_td);
    end

    // Exit delay, with a repeated ArmRequest that must not restart it.
    drive(0, 0, 0, 4'h0, 1, 0);
    tick();
    chk_all("arm.c1", 0, 0, 0, 0, 3'd1, 4'h0);
    for (int i = 2; i <= 4; i++) begin
      drive(0, 0, 0, 4'h0, (i == 2), 0);
      tick();
      chk_all($sformatf("arm.c%0d", i), 0, 0, 0, 0, 3'd1, 4'h0);
    end
    drive(0, 0, 0, 4'h0, 0, 0);
    tick();
    chk_all("arm.done", 0, 0, 1, 0, 3'd2, 4'h0);
    drive(0, 0, 0, 4'h0, 0, 1);
    tick();
    chk_all("arm.disarm", 0, 0, 0, 0, 3'd0, 4'h0);

    // Aborted arm: door[2] open on the last ARMING cycle.
    drive(0, 0, 0, 4'h0, 1, 0);
    tick();
    drive(0, 0, 0, 4'h0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    chk_all("fail.c4", 0, 0, 0, 0, 3'd1, 4'h0);
    drive(0, 0, 0, 4'h4, 0, 0);
    tick();
    chk_all("fail.pulse", 0, 0, 0, 1, 3'd0, 4'h0);
    drive(0, 0, 0, 4'h0, 0, 0);
    tick();
    chk_all("fail.clear", 0, 0, 0, 0, 3'd0, 4'h0);

    // Full entry/alarm episode from door[1].
    arm_ok("ep");
    drive(0, 0, 0, 4'h2, 0, 0);
    tick();
    chk_all("ep.entry1", 0, 0, 1, 0, 3'd3, 4'h2);
    drive(0, 0, 0, 4'h0, 0, 0);
    for (int i = 2; i <= 8; i++) begin
      tick();
      chk_all($sformatf("ep.entry%0d", i), 0, 0, 1, 0, 3'd3, 4'h2);
    end
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk_all($sformatf("ep.siren%0d", i), 0, 1, 1, 0, 3'd4, 4'h2);
    end
    tick();
    chk_all("ep.rearmed", 0, 0, 1, 0, 3'd2, 4'h2);
    drive(0, 0, 0, 4'h0, 0, 1);
    tick();
    chk_all("ep.disarm", 0, 0, 0, 0, 3'd0, 4'h0);

    // Disarm at ENTRY cycle 5.
    arm_ok("ed");
    drive(0, 0, 0, 4'h2, 0, 0);
    tick();
    drive(0, 0, 0, 4'h0, 0, 0);
    for (int i = 2; i <= 5; i++) tick();
    chk_all("ed.entry5", 0, 0, 1, 0, 3'd3, 4'h2);
    drive(0, 0, 0, 4'h0, 0, 1);
    tick();
    chk_all("ed.disarm", 0, 0, 0, 0, 3'd0, 4'h0);
    drive(0, 0, 0, 4'h0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_all("ed.idle", 0, 0, 0, 0, 3'd0, 4'h0);
    end

    // Ignition and door[3] together in ARMED: tamper wins, no door recorded.
    arm_ok("tp");
    drive(0, 1, 0, 4'h8, 0, 0);
    tick();
    chk_all("tp.alarm", 0, 1, 1, 0, 3'd4, 4'h0);
    drive(0, 0, 0, 4'h0, 0, 1);
    tick();
    chk_all("tp.disarm", 0, 0, 0, 0, 3'd0, 4'h0);

    // Door[0] held open: three episodes then lockout.
    arm_ok("lk");
    drive(0, 0, 0, 4'h1, 0, 0);
    for (int ep = 1; ep <= 3; ep++) begin
      for (int i = 1; i <= 8; i++) begin
        tick();
        chk_all($sformatf("lk.e%0d.entry%0d", ep, i), 0, 0, 1, 0, 3'd3, 4'h1);
      end
      for (int i = 1; i <= 16; i++) begin
        tick();
        chk_all($sformatf("lk.e%0d.siren%0d", ep, i), 0, 1, 1, 0, 3'd4, 4'h1);
      end
      tick();
      if (ep < 3) chk_all($sformatf("lk.e%0d.armed", ep), 0, 0, 1, 0, 3'd2, 4'h1);
      else        chk_all("lk.lockout", 0, 0, 1, 0, 3'd5, 4'h1);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("lk.hold", 0, 0, 1, 0, 3'd5, 4'h1);
    end
    drive(0, 0, 0, 4'h0, 0, 1);
    tick();
    chk_all("lk.disarm", 0, 0, 0, 0, 3'd0, 4'h0);

    // Reset mid-siren, then simultaneous arm and disarm.
    arm_ok("rs");
    drive(0, 0, 0, 4'h2, 0, 0);
    tick();
    drive(0, 0, 0, 4'h0, 0, 0);
    for (int i = 2; i <= 8; i++) tick();
    for (int i = 1; i <= 7; i++) tick();
    chk_all("rs.siren7", 0, 1, 1, 0, 3'd4, 4'h2);
    drive(1, 0, 0, 4'h0, 0, 0);
    tick();
    chk_all("rs.reset", 0, 0, 0, 0, 3'd0, 4'h0);
    drive(0, 0, 0, 4'h0, 1, 1);
    tick();
    chk_all("rs.armdis", 0, 0, 0, 0, 3'd0, 4'h0);
    drive(0, 0, 0, 4'h0, 0, 0);
    tick();
    chk_all("rs.idle", 0, 0, 0, 0, 3'd0, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
